// File: rtl/dmem_responder_pkg.sv
// Shared FSM encoding, counter width and address helpers for the dmem_responder slice.
package dmem_responder_pkg;

   localparam int CNT_W       = 4;
   localparam int WORD_OFFSET = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   typedef logic [CNT_W-1:0] cnt_t;

   // A request errors when it is not word aligned or points past the last stored word.
   function automatic logic addr_error(input logic [31:0] addr, input logic [31:0] depth_words);
      logic [31:0] word_idx;
      word_idx = {{WORD_OFFSET{1'b0}}, addr[31:WORD_OFFSET]};
      return (addr[WORD_OFFSET-1:0] != '0) || (word_idx >= depth_words);
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a CPU (master) and the data memory responder (slave).
// The optional req_wstrb lane exists only when DMEM_BYTE_STROBE_EN is defined.
interface dmem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
   logic [3:0]  req_wstrb;
`endif
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_error;

   modport master (
`ifdef DMEM_BYTE_STROBE_EN
      output req_wstrb,
`endif
      output req_valid,
      output req_write,
      output req_addr,
      output req_wdata,
      output resp_ready,
      input  req_ready,
      input  resp_valid,
      input  resp_rdata,
      input  resp_error
   );

   modport slave (
`ifdef DMEM_BYTE_STROBE_EN
      input  req_wstrb,
`endif
      input  req_valid,
      input  req_write,
      input  req_addr,
      input  req_wdata,
      input  resp_ready,
      output req_ready,
      output resp_valid,
      output resp_rdata,
      output resp_error
   );

endinterface

// File: rtl/dmem_responder_array.sv
// Word storage for dmem_responder: synchronous byte-enabled write, combinational read.
module dmem_array #(
   parameter  int DEPTH_WORDS = 256,
   localparam int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clock,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_idx,
   input  logic [31:0]   wr_data,
   input  logic [3:0]    wr_be,
   input  logic [AW-1:0] rd_idx,
   output logic [31:0]   rd_data
);

   // Contents survive reset; the initialiser only gives simulation a known start.
   logic [31:0] mem_words [DEPTH_WORDS] = '{default: 32'h0};

   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
               mem_words[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   assign rd_data = mem_words[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data memory responder with fixed wait states and address error checking.
// Define DMEM_BYTE_STROBE_EN to enable per-byte store strobes (req_wstrb).
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input logic           clock,
   input logic           reset,
   dmem_responder_if.slave bus
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_e      state_q, state_d;
   cnt_t        cnt_q, cnt_d;
   logic        cap_write_q, cap_write_d;
   logic [31:0] cap_addr_q, cap_addr_d;
   logic [31:0] cap_wdata_q, cap_wdata_d;
   logic [3:0]  cap_wstrb_q, cap_wstrb_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_error_q, resp_error_d;

   logic        txn_write;
   logic [31:0] txn_addr;
   logic [31:0] txn_wdata;
   logic [3:0]  txn_wstrb;
   logic        txn_err;
   logic [3:0]  live_wstrb;
   logic        enter_resp;
   logic        mem_we;
   logic [31:0] mem_rdata;

`ifdef DMEM_BYTE_STROBE_EN
   assign live_wstrb = bus.req_wstrb;
`else
   assign live_wstrb = 4'b1111;
`endif

   // With zero wait states RESP is entered on the accept edge itself, so the live request is used.
   always_comb begin
      if (state_q == ST_IDLE) begin
         txn_write = bus.req_write;
         txn_addr  = bus.req_addr;
         txn_wdata = bus.req_wdata;
         txn_wstrb = live_wstrb;
      end else begin
         txn_write = cap_write_q;
         txn_addr  = cap_addr_q;
         txn_wdata = cap_wdata_q;
         txn_wstrb = cap_wstrb_q;
      end
      txn_err = addr_error(txn_addr, 32'(DEPTH_WORDS));
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cap_write_d  = cap_write_q;
      cap_addr_d   = cap_addr_q;
      cap_wdata_d  = cap_wdata_q;
      cap_wstrb_d  = cap_wstrb_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_error_d = resp_error_q;
      enter_resp   = 1'b0;
      mem_we       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               cap_write_d = bus.req_write;
               cap_addr_d  = bus.req_addr;
               cap_wdata_d = bus.req_wdata;
               cap_wstrb_d = live_wstrb;
               req_ready_d = 1'b0;
               if (WAIT_CYCLES == 0) begin
                  state_d    = ST_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = cnt_t'(WAIT_CYCLES);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - cnt_t'(1);
            end
            if (cnt_q <= cnt_t'(1)) begin
               state_d    = ST_RESP;
               enter_resp = 1'b1;
            end
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               state_d      = ST_IDLE;
               req_ready_d  = 1'b1;
               resp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            req_ready_d  = 1'b1;
            resp_valid_d = 1'b0;
         end
      endcase

      // Stores commit only on the edge that enters RESP, and never while reset is held.
      if (enter_resp) begin
         resp_valid_d = 1'b1;
         resp_error_d = txn_err;
         resp_rdata_d = (txn_write || txn_err) ? 32'h0 : mem_rdata;
         mem_we       = txn_write && !txn_err && !reset;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         cap_write_q  <= 1'b0;
         cap_addr_q   <= '0;
         cap_wdata_q  <= '0;
         cap_wstrb_q  <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cap_write_q  <= cap_write_d;
         cap_addr_q   <= cap_addr_d;
         cap_wdata_q  <= cap_wdata_d;
         cap_wstrb_q  <= cap_wstrb_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_error_q <= resp_error_d;
      end
   end

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_array (
      .clock  (clock),
      .wr_en  (mem_we),
      .wr_idx (txn_addr[WORD_OFFSET +: AW]),
      .wr_data(txn_wdata),
      .wr_be  (txn_wstrb),
      .rd_idx (txn_addr[WORD_OFFSET +: AW]),
      .rd_data(mem_rdata)
   );

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_error = resp_error_q;

endmodule
